// File: rtl/faultconf_fsm.sv
// ---------------------------------------------------------------------------
// faultconf_fsm
//
// CAN fault-confinement state machine. It consumes the threshold flags of the
// transmit (TEC) and receive (REC) error counters and tracks the node state:
// error-active, error-passive or bus-off. In bus-off it counts RECOVERY_SEQ
// sequences of REC_BITS consecutive recessive bits. It then returns to
// error-active and pulses a one-cycle clear to both error counters.
//
// Parameters
//   REC_BITS      consecutive recessive bits forming one recovery sequence (2..31)
//   RECOVERY_SEQ  sequences required to leave bus-off (1..255)
//
// Ports
//   clock        in   rising-edge system clock
//   reset        in   synchronous, active-low
//   tec_ge96     in   TEC >= 96
//   tec_ge128    in   TEC >= 128
//   tec_ge256    in   TEC >= 256
//   rec_ge96     in   REC >= 96
//   rec_ge128    in   REC >= 128
//   bitstrobe    in   one-cycle pulse per sampled bus bit
//   rxbit        in   sampled bus level, 1 = recessive (qualified by bitstrobe)
//   erroractive  out  node is error-active (registered, one-hot with the next two)
//   errorpassive out  node is error-passive
//   busoff       out  node is bus-off
//   warning      out  registered tec_ge96 | rec_ge96
//   cnt_rst_n    out  active-low one-cycle clear for the TEC and REC counters
//   state_irq    out  one-cycle pulse in the first cycle showing a new state
//   seqcount     out  completed recovery sequences
// ---------------------------------------------------------------------------
module faultconf_fsm #(
    parameter int REC_BITS     = 11,
    parameter int RECOVERY_SEQ = 128
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tec_ge96,
    input  logic       tec_ge128,
    input  logic       tec_ge256,
    input  logic       rec_ge96,
    input  logic       rec_ge128,
    input  logic       bitstrobe,
    input  logic       rxbit,
    output logic       erroractive,
    output logic       errorpassive,
    output logic       busoff,
    output logic       warning,
    output logic       cnt_rst_n,
    output logic       state_irq,
    output logic [7:0] seqcount
);

    // One-hot state encoding so the three state outputs come straight from flops.
    localparam logic [2:0] ST_ACTIVE  = 3'b001;
    localparam logic [2:0] ST_PASSIVE = 3'b010;
    localparam logic [2:0] ST_BUSOFF  = 3'b100;

    localparam logic [4:0] BIT_LAST = 5'(REC_BITS - 1);
    localparam logic [7:0] SEQ_MAX  = 8'(RECOVERY_SEQ);

    logic [2:0] state_p1;
    logic [2:0] state_next;
    logic [4:0] bitcnt_p1;
    logic [4:0] bitcnt_next;
    logic [7:0] seq_p1;
    logic [7:0] seq_next;
    logic       warning_p1;
    logic       cnt_rst_n_p1;
    logic       state_irq_p1;
    logic       recover;

    // Saturating increment of the sequence counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        if (v >= SEQ_MAX) begin
            return SEQ_MAX;
        end
        return v + 8'd1;
    endfunction

    // -------------------------------------------------------------------
    // Stage p1: state register and all status flops
    // -------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_p1     <= ST_ACTIVE;
            bitcnt_p1    <= '0;
            seq_p1       <= '0;
            warning_p1   <= 1'b0;
            cnt_rst_n_p1 <= 1'b1;
            state_irq_p1 <= 1'b0;
        end else begin
            state_p1     <= state_next;
            bitcnt_p1    <= bitcnt_next;
            seq_p1       <= seq_next;
            // The flags are stale on the recovery edge and for the clear
            // cycle that follows, so warning is held low across both.
            warning_p1   <= (tec_ge96 | rec_ge96) & cnt_rst_n_p1 & ~recover;
            cnt_rst_n_p1 <= ~recover;
            state_irq_p1 <= (state_next != state_p1);
        end
    end

    // -------------------------------------------------------------------
    // Next-state and recovery counting
    // -------------------------------------------------------------------
    always_comb begin
        state_next  = state_p1;
        bitcnt_next = '0;
        seq_next    = '0;
        recover     = 1'b0;
        case (state_p1)
            ST_ACTIVE: begin
                // During the counter clear cycle the flags still describe
                // the old counts and must not pull the node back out.
                if (cnt_rst_n_p1) begin
                    if (tec_ge256) begin
                        state_next = ST_BUSOFF;
                    end else if (tec_ge128 | rec_ge128) begin
                        state_next = ST_PASSIVE;
                    end
                end
            end
            ST_PASSIVE: begin
                if (tec_ge256) begin
                    state_next = ST_BUSOFF;
                end else if (!tec_ge128 && !rec_ge128) begin
                    state_next = ST_ACTIVE;
                end
            end
            ST_BUSOFF: begin
                bitcnt_next = bitcnt_p1;
                seq_next    = seq_p1;
                if (bitstrobe) begin
                    if (!rxbit) begin
                        bitcnt_next = '0;
                    end else if (bitcnt_p1 == BIT_LAST) begin
                        // This strobe completes a sequence: wrap the bit
                        // counter and credit the sequence in the same edge.
                        bitcnt_next = '0;
                        seq_next    = sat_inc(seq_p1);
                        if (seq_next == SEQ_MAX) begin
                            recover    = 1'b1;
                            state_next = ST_ACTIVE;
                        end
                    end else begin
                        bitcnt_next = bitcnt_p1 + 5'd1;
                    end
                end
                // Counters hold zero outside bus-off.
                if (recover) begin
                    bitcnt_next = '0;
                    seq_next    = '0;
                end
            end
            default: begin
                state_next = ST_ACTIVE;
            end
        endcase
    end

    // -------------------------------------------------------------------
    // Output decode (all sources are flops)
    // -------------------------------------------------------------------
    always_comb begin
        erroractive  = state_p1[0];
        errorpassive = state_p1[1];
        busoff       = state_p1[2];
        warning      = warning_p1;
        cnt_rst_n    = cnt_rst_n_p1;
        state_irq    = state_irq_p1;
        seqcount     = seq_p1;
    end

endmodule

// File: tb/tb_faultconf_fsm.sv
module tb_faultconf_fsm;

    localparam int REC_BITS     = 11;
    localparam int RECOVERY_SEQ = 128;

    logic       clock = 1'b0;
    logic       reset;
    logic       tec_ge96, tec_ge128, tec_ge256, rec_ge96, rec_ge128;
    logic       bitstrobe, rxbit;
    logic       erroractive, errorpassive, busoff, warning, cnt_rst_n, state_irq;
    logic [7:0] seqcount;

    int checks   = 0;
    int failures = 0;

    faultconf_fsm #(.REC_BITS(REC_BITS), .RECOVERY_SEQ(RECOVERY_SEQ)) dut (
        .clock       (clock),
        .reset       (reset),
        .tec_ge96    (tec_ge96),
        .tec_ge128   (tec_ge128),
        .tec_ge256   (tec_ge256),
        .rec_ge96    (rec_ge96),
        .rec_ge128   (rec_ge128),
        .bitstrobe   (bitstrobe),
        .rxbit       (rxbit),
        .erroractive (erroractive),
        .errorpassive(errorpassive),
        .busoff      (busoff),
        .warning     (warning),
        .cnt_rst_n   (cnt_rst_n),
        .state_irq   (state_irq),
        .seqcount    (seqcount)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected state as {busoff, errorpassive, erroractive}.
    task automatic chk_state(input string tag, input logic [2:0] exp);
        chk(tag, {5'd0, busoff, errorpassive, erroractive}, {5'd0, exp});
    endtask

    task automatic strobe(input logic b);
        bitstrobe = 1'b1;
        rxbit     = b;
        tick();
        bitstrobe = 1'b0;
        rxbit     = 1'b0;
    endtask

    task automatic run_seqs(input int n);
        for (int s = 0; s < n; s++) begin
            for (int b = 0; b < REC_BITS; b++) begin
                strobe(1'b1);
            end
        end
    endtask

    initial begin
        // 1: reset with every input high
        reset = 1'b0;
        {tec_ge96, tec_ge128, tec_ge256, rec_ge96, rec_ge128, bitstrobe, rxbit} = '1;
        tick();
        tick();
        chk_state("rst_state", 3'b001);
        chk("rst_warning", {7'd0, warning}, 8'd0);
        chk("rst_cnt_rst_n", {7'd0, cnt_rst_n}, 8'd1);
        chk("rst_irq", {7'd0, state_irq}, 8'd0);
        chk("rst_seqcount", seqcount, 8'd0);

        reset = 1'b1;
        {tec_ge96, tec_ge128, tec_ge256, rec_ge96, rec_ge128, bitstrobe, rxbit} = '0;
        tick();
        chk_state("idle_active", 3'b001);
        chk("idle_irq", {7'd0, state_irq}, 8'd0);

        // Bit strobes are ignored outside bus-off
        run_seqs(1);
        chk("active_seq_ignored", seqcount, 8'd0);

        // 2: ACTIVE -> PASSIVE -> ACTIVE
        tec_ge128 = 1'b1;
        tick();
        chk_state("to_passive", 3'b010);
        chk("to_passive_irq", {7'd0, state_irq}, 8'd1);
        tick();
        chk_state("hold_passive", 3'b010);
        chk("hold_passive_irq", {7'd0, state_irq}, 8'd0);
        tec_ge128 = 1'b0;
        tick();
        chk_state("back_active", 3'b001);
        chk("back_active_irq", {7'd0, state_irq}, 8'd1);

        // Warning follows the >=96 flags with one cycle of latency
        rec_ge96 = 1'b1;
        tick();
        chk("warning_on", {7'd0, warning}, 8'd1);
        rec_ge96 = 1'b0;
        tick();
        chk("warning_off", {7'd0, warning}, 8'd0);

        // 3: tec_ge256 together with rec_ge128 goes straight to bus-off
        tec_ge256 = 1'b1;
        rec_ge128 = 1'b1;
        tec_ge96  = 1'b1;
        tick();
        chk_state("to_busoff", 3'b100);
        chk("to_busoff_irq", {7'd0, state_irq}, 8'd1);
        chk("busoff_warning", {7'd0, warning}, 8'd1);
        chk("busoff_seq0", seqcount, 8'd0);
        rec_ge128 = 1'b0;

        // 5: a dominant bit discards a partial sequence
        for (int i = 0; i < 10; i++) strobe(1'b1);
        strobe(1'b0);
        chk("partial_seq", seqcount, 8'd0);
        run_seqs(1);
        chk("one_seq", seqcount, 8'd1);
        chk_state("still_busoff", 3'b100);

        // 4: finish recovery while tec_ge256 is still reported
        run_seqs(RECOVERY_SEQ - 2);
        for (int i = 0; i < REC_BITS - 1; i++) strobe(1'b1);
        chk("seq_before_last", seqcount, 8'd127);
        chk_state("busoff_before_last", 3'b100);
        strobe(1'b1);
        chk_state("recovered", 3'b001);
        chk("recovered_cnt_rst_n", {7'd0, cnt_rst_n}, 8'd0);
        chk("recovered_irq", {7'd0, state_irq}, 8'd1);
        chk("recovered_seq", seqcount, 8'd0);
        chk("recovered_warning", {7'd0, warning}, 8'd0);
        tick();
        chk_state("stale_flags_ignored", 3'b001);
        chk("clear_released", {7'd0, cnt_rst_n}, 8'd1);
        chk("post_clear_irq", {7'd0, state_irq}, 8'd0);
        chk("post_clear_warning", {7'd0, warning}, 8'd0);
        tec_ge256 = 1'b0;
        tec_ge96  = 1'b0;
        tick();
        chk_state("active_after_clear", 3'b001);

        // PASSIVE -> BUSOFF via tec_ge256, then flags cleared stay ignored
        rec_ge128 = 1'b1;
        tick();
        chk_state("passive_again", 3'b010);
        tec_ge256 = 1'b1;
        tick();
        chk_state("passive_to_busoff", 3'b100);
        {tec_ge256, rec_ge128} = '0;
        tick();
        chk_state("busoff_ignores_flags", 3'b100);

        // 6: reset during bus-off with seqcount=50
        run_seqs(50);
        chk("seq_50", seqcount, 8'd50);
        reset = 1'b0;
        tick();
        chk_state("reset_from_busoff", 3'b001);
        chk("reset_seq", seqcount, 8'd0);
        chk("reset_no_clear", {7'd0, cnt_rst_n}, 8'd1);
        reset = 1'b1;
        tick();
        chk("after_reset_no_clear", {7'd0, cnt_rst_n}, 8'd1);
        chk_state("after_reset_active", 3'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
